myo_spi_frame_sequencer: RTL and testbench

Frame sequencer between the per-bus motor controller and the 16-bit SPI master. On a start pulse it runs one fixed 8-word full-duplex frame with the currently selected motor board: it sends a start-of-frame word and the PWM reference, then collects position, velocity, current, displacement and two sensor words. Results are presented atomically, and completion is signalled with a level `spi_done` whose rising edge the controller uses to latch data and advance to the next motor.

---
 rtl/myo_spi_frame_sequencer.sv | 119 +++++++++++
 tb/tb_myo_spi_frame_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/myo_spi_frame_sequencer.sv
// myo_spi_frame_sequencer: runs one fixed 8-word full-duplex SPI frame per start pulse
// and commits the received words atomically.
// Ports:
//   clock, reset              : system clock and synchronous active-high reset
//   start, pwmRef             : frame request and PWM reference captured at start
//   di_req, write_ack, Word, wren : transmit handshake with the SPI master
//   data_read_valid, data_read    : received words from the SPI master
//   spi_done                  : level, high when idle or the frame is finished
//   position .. sensor2       : frame results, updated together on a complete frame
//   frame_error, error_count  : last frame timed out / saturating timeout count
module myo_spi_frame_sequencer #(
    parameter logic [15:0] SOF_WORD       = 16'h8000,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] pwmRef,
    input  logic               di_req,
    input  logic               write_ack,
    input  logic               data_read_valid,
    input  logic        [15:0] data_read,
    output logic        [15:0] Word,
    output logic               wren,
    output logic               spi_done,
    output logic signed [31:0] position,
    output logic signed [15:0] velocity,
    output logic signed [15:0] current,
    output logic        [15:0] displacement,
    output logic signed [15:0] sensor1,
    output logic signed [15:0] sensor2,
    output logic               frame_error,
    output logic        [15:0] error_count
);
    localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {BOOT, IDLE, WRITE, WAIT_REQ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    tx_idx_q, tx_idx_d;
    logic [3:0]    rx_idx_q, rx_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   pwm_q, pwm_d;
    logic [15:0]   sh_q [1:6];
    logic          active, rx_take, done, timeout;

    always_comb begin
        state_d  = state_q;
        tx_idx_d = tx_idx_q;
        pwm_d    = pwm_q;
        active   = state_q inside {WRITE, WAIT_REQ, DRAIN};
        rx_take  = active && data_read_valid;
        done     = rx_take && rx_idx_q == 4'd7;
        // a valid in the same cycle as the limit restarts the window, so it wins
        timeout  = active && !data_read_valid && timer_q == T_LAST;
        timer_d  = active ? (data_read_valid ? '0 : timer_q + 1'b1) : timer_q;
        rx_idx_d = rx_take ? rx_idx_q + 4'd1 : rx_idx_q;
        case (state_q)
            BOOT: state_d = IDLE;
            IDLE: if (start) begin
                state_d  = WRITE;
                tx_idx_d = '0;
                rx_idx_d = '0;
                timer_d  = '0;
                pwm_d    = pwmRef;
            end
            WRITE: if (write_ack) begin
                tx_idx_d = tx_idx_q + 4'd1;
                state_d  = WAIT_REQ;
            end
            WAIT_REQ: state_d = tx_idx_q == 4'd8 ? DRAIN : (di_req ? WRITE : WAIT_REQ);
            default: ;
        endcase
        if (done || timeout) state_d = IDLE;
        wren     = state_q == WRITE;
        spi_done = state_q == IDLE;
        Word     = !wren ? '0 : tx_idx_q == 4'd0 ? SOF_WORD : tx_idx_q == 4'd1 ? pwm_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BOOT;
            tx_idx_q     <= '0;
            rx_idx_q     <= '0;
            timer_q      <= '0;
            pwm_q        <= '0;
            for (int i = 1; i <= 6; i++) sh_q[i] <= '0;
            position     <= '0;
            velocity     <= '0;
            current      <= '0;
            displacement <= '0;
            sensor1      <= '0;
            sensor2      <= '0;
            frame_error  <= 1'b0;
            error_count  <= '0;
        end else begin
            state_q  <= state_d;
            tx_idx_q <= tx_idx_d;
            rx_idx_q <= rx_idx_d;
            timer_q  <= timer_d;
            pwm_q    <= pwm_d;
            // word 0 is a dummy and word 7 goes straight to the outputs
            if (rx_take && rx_idx_q >= 4'd1 && rx_idx_q <= 4'd6) sh_q[rx_idx_q[2:0]] <= data_read;
            if (done) begin
                position     <= {sh_q[1], sh_q[2]};
                velocity     <= sh_q[3];
                current      <= sh_q[4];
                displacement <= sh_q[5];
                sensor1      <= sh_q[6];
                sensor2      <= data_read;
                frame_error  <= 1'b0;
            end else if (timeout) begin
                frame_error <= 1'b1;
                error_count <= &error_count ? error_count : error_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_myo_spi_frame_sequencer.sv
// tb_myo_spi_frame_sequencer: scoreboard bench with an SPI master model for the frame sequencer.
module tb_myo_spi_frame_sequencer;
    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] pwmRef = '0;
    logic               di_req = 1'b0;
    logic               write_ack = 1'b0;
    logic               data_read_valid = 1'b0;
    logic        [15:0] data_read = '0;
    logic        [15:0] Word;
    logic               wren, spi_done, frame_error;
    logic signed [31:0] position;
    logic signed [15:0] velocity, current, sensor1, sensor2;
    logic        [15:0] displacement, error_count;

    myo_spi_frame_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .pwmRef(pwmRef),
        .di_req(di_req), .write_ack(write_ack),
        .data_read_valid(data_read_valid), .data_read(data_read),
        .Word(Word), .wren(wren), .spi_done(spi_done),
        .position(position), .velocity(velocity), .current(current),
        .displacement(displacement), .sensor1(sensor1), .sensor2(sensor2),
        .frame_error(frame_error), .error_count(error_count)
    );

    always #5 clock = ~clock;

    int          n_vec = 0, n_err = 0;
    logic [15:0] txq [$];
    int          dueq [$];
    logic [31:0] e_pos = '0;
    logic [15:0] e_vel = '0, e_cur = '0, e_disp = '0, e_s1 = '0, e_s2 = '0, e_cnt = '0;
    logic        e_ferr = 1'b0;

    logic [15:0] rx_a [8] = '{16'hFFFF, 16'h0001, 16'h0002, 16'h0010, 16'hFFF0, 16'h0100, 16'h0AAA, 16'h0555};
    logic [15:0] rx_b [8] = '{16'h1234, 16'h8000, 16'h7FFF, 16'hFF80, 16'h0040, 16'hBEEF, 16'h0003, 16'hC001};
    logic [15:0] rx_c [8] = '{16'h0000, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".position"}, position, e_pos);
        check({tag, ".velocity"}, {16'h0, velocity}, {16'h0, e_vel});
        check({tag, ".current"}, {16'h0, current}, {16'h0, e_cur});
        check({tag, ".displacement"}, {16'h0, displacement}, {16'h0, e_disp});
        check({tag, ".sensor1"}, {16'h0, sensor1}, {16'h0, e_s1});
        check({tag, ".sensor2"}, {16'h0, sensor2}, {16'h0, e_s2});
        check({tag, ".frame_error"}, {31'h0, frame_error}, {31'h0, e_ferr});
        check({tag, ".error_count"}, {16'h0, error_count}, {16'h0, e_cnt});
    endtask

    task automatic clear_model;
        e_pos = '0; e_vel = '0; e_cur = '0; e_disp = '0; e_s1 = '0; e_s2 = '0; e_cnt = '0; e_ferr = 1'b0;
    endtask

    task automatic idle_inputs;
        start = 1'b0; write_ack = 1'b0; data_read_valid = 1'b0; di_req = 1'b0;
    endtask

    // lag: cycles from a write ack to the matching RX pulse; nrx: RX pulses delivered;
    // busy_at/rst_at: ack count at which to pulse start / assert reset (0 = never)
    task automatic run_frame(input logic [15:0] pwm, input logic [15:0] rx [8], input int lag,
                             input int nrx, input int busy_at, input int rst_at, input int extras);
        int acks = 0, sent = 0, cyc = 0, last_dv = 0;
        bit acked_prev = 0, wait_done = 0, fin = 0;
        check("idle_before_start", {31'h0, spi_done}, 1);
        txq.delete();
        dueq.delete();
        txq.push_back(16'h8000);
        txq.push_back(pwm);
        for (int i = 0; i < 6; i++) txq.push_back(16'h0000);
        start = 1'b1;
        pwmRef = pwm;
        @(negedge clock);
        start = 1'b0;
        pwmRef = ~pwm;
        check("start_spi_done_low", {31'h0, spi_done}, 0);
        check("start_wren_high", {31'h0, wren}, 1);
        while (!fin) begin
            if (wait_done) begin
                idle_inputs();
                check("done_after_8th", {31'h0, spi_done}, 1);
                e_pos = {rx[1], rx[2]}; e_vel = rx[3]; e_cur = rx[4];
                e_disp = rx[5]; e_s1 = rx[6]; e_s2 = rx[7]; e_ferr = 1'b0;
                check_outs("commit");
                fin = 1;
            end else if (spi_done) begin
                idle_inputs();
                check("timeout_latency", {31'h0, (cyc - last_dv) >= 2000 && (cyc - last_dv) <= 2001}, 1);
                check("timeout_short_frame", {31'h0, sent < 8}, 1);
                e_ferr = 1'b1;
                e_cnt = e_cnt + 16'd1;
                check_outs("timeout");
                fin = 1;
            end else if (cyc > 3000) begin
                idle_inputs();
                check("frame_cycle_bound", {31'h0, spi_done}, 1);
                fin = 1;
            end else begin
                write_ack = 1'b0;
                data_read_valid = 1'b0;
                start = 1'b0;
                if (acked_prev) check("wren_drop_after_ack", {31'h0, wren}, 0);
                di_req = acked_prev;
                acked_prev = 0;
                if (wren) begin
                    if (txq.size() == 0) check("unexpected_write", {16'h0, Word}, 32'hFFFF_FFFF);
                    else check("tx_word", {16'h0, Word}, {16'h0, txq.pop_front()});
                    write_ack = 1'b1;
                    acks++;
                    acked_prev = 1;
                    dueq.push_back(cyc + lag);
                    if (acks == busy_at) start = 1'b1;
                end
                if (dueq.size() > 0 && dueq[0] <= cyc) begin
                    void'(dueq.pop_front());
                    if (sent < nrx) begin
                        data_read_valid = 1'b1;
                        data_read = rx[sent];
                        sent++;
                        last_dv = cyc;
                        wait_done = sent == 8;
                    end
                end
                if (rst_at > 0 && acks == rst_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    idle_inputs();
                    clear_model();
                    check("rst_spi_done", {31'h0, spi_done}, 0);
                    check("rst_wren", {31'h0, wren}, 0);
                    check("rst_word", {16'h0, Word}, 0);
                    check_outs("rst_mid");
                    reset = 1'b0;
                    #1 check("rst_release_spi_done", {31'h0, spi_done}, 0);
                    @(negedge clock);
                    check("rst_boot_spi_done", {31'h0, spi_done}, 1);
                    return;
                end
                cyc++;
                @(negedge clock);
            end
        end
        check("ack_count", acks, 8);
        check("tx_queue_empty", txq.size(), 0);
        for (int i = 0; i < extras; i++) begin
            data_read_valid = 1'b1;
            data_read = 16'hDEAD;
            @(negedge clock);
            data_read_valid = 1'b0;
            @(negedge clock);
        end
        if (extras > 0) begin
            check_outs("extra_pulses");
            check("extra_spi_done", {31'h0, spi_done}, 1);
            check("extra_no_wren", {31'h0, wren}, 0);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_spi_done", {31'h0, spi_done}, 0);
        check("reset_wren", {31'h0, wren}, 0);
        check("reset_word", {16'h0, Word}, 0);
        check_outs("reset");
        reset = 1'b0;
        #1 check("release_spi_done", {31'h0, spi_done}, 0);
        @(negedge clock);
        check("boot_spi_done", {31'h0, spi_done}, 1);
        run_frame(16'h0123, rx_a, 1, 8, 0, 0, 0);
        check("nominal_position", position, 32'h0001_0002);
        check("nominal_velocity", {16'h0, velocity}, 32'd16);
        check("nominal_current", {{16{current[15]}}, current}, 32'hFFFF_FFF0);
        run_frame(16'h7F00, rx_b, 2, 8, 3, 0, 0);
        run_frame(16'h1111, rx_c, 3, 4, 0, 0, 0);
        run_frame(16'h2222, rx_b, 3, 8, 0, 0, 0);
        check("count_after_good", {16'h0, error_count}, 1);
        run_frame(16'h3333, rx_c, 1, 8, 0, 5, 0);
        run_frame(16'h8001, rx_a, 0, 8, 0, 0, 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
